// File: rtl/gat_layer_scheduler.sv
// GAT layer sequencer: streams H-data, node-info and weight words into the core BRAMs,
// kicks one layer, waits for completion, then streams the new-feature BRAM out.
module gat_layer_scheduler #(
    parameter int S_WIDTH            = 32,
    parameter int DATA_WIDTH         = 8,
    parameter int H_DATA_WIDTH       = 19,
    parameter int NODE_INFO_WIDTH    = 20,
    parameter int H_DATA_ADDR_W      = 18,
    parameter int NODE_INFO_ADDR_W   = 14,
    parameter int WEIGHT_ADDR_W      = 15,
    parameter int NEW_FEATURE_ADDR_W = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [H_DATA_ADDR_W:0]        h_data_cnt,
    input  logic [NODE_INFO_ADDR_W:0]     node_info_cnt,
    input  logic [WEIGHT_ADDR_W:0]        wgt_cnt,
    input  logic [NEW_FEATURE_ADDR_W:0]   feat_cnt,
    output logic                          busy,
    output logic                          done,
    input  logic [S_WIDTH-1:0]            s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [H_DATA_WIDTH-1:0]       h_data_bram_din,
    output logic                          h_data_bram_ena,
    output logic                          h_data_bram_wea,
    output logic [H_DATA_ADDR_W+1:0]      h_data_bram_addra,
    output logic [NODE_INFO_WIDTH-1:0]    h_node_info_bram_din,
    output logic                          h_node_info_bram_ena,
    output logic                          h_node_info_bram_wea,
    output logic [NODE_INFO_ADDR_W+1:0]   h_node_info_bram_addra,
    output logic [DATA_WIDTH-1:0]         wgt_bram_din,
    output logic                          wgt_bram_ena,
    output logic                          wgt_bram_wea,
    output logic [WEIGHT_ADDR_W+1:0]      wgt_bram_addra,
    output logic                          h_data_bram_load_done,
    output logic                          h_node_info_bram_load_done,
    output logic                          wgt_bram_load_done,
    output logic                          gat_layer,
    input  logic                          gat_ready,
    output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
    input  logic [DATA_WIDTH-1:0]         feat_bram_dout,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic                          m_valid,
    input  logic                          m_ready
);

    localparam int MAX_HN = (H_DATA_ADDR_W > NODE_INFO_ADDR_W) ? H_DATA_ADDR_W : NODE_INFO_ADDR_W;
    localparam int MAX_WF = (WEIGHT_ADDR_W > NEW_FEATURE_ADDR_W) ? WEIGHT_ADDR_W : NEW_FEATURE_ADDR_W;
    localparam int IDX_W  = ((MAX_HN > MAX_WF) ? MAX_HN : MAX_WF) + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_LD_H, S_LD_NI, S_LD_W, S_KICK, S_RUN,
        S_RD_ADDR, S_RD_WAIT, S_RD_OUT, S_DONE
    } state_t;

    state_t                        state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic                          fin_q, fin_d;
    logic [H_DATA_ADDR_W:0]        h_cnt_q, h_cnt_d;
    logic [NODE_INFO_ADDR_W:0]     ni_cnt_q, ni_cnt_d;
    logic [WEIGHT_ADDR_W:0]        w_cnt_q, w_cnt_d;
    logic [NEW_FEATURE_ADDR_W:0]   f_cnt_q, f_cnt_d;
    logic                          h_done_q, h_done_d;
    logic                          ni_done_q, ni_done_d;
    logic                          w_done_q, w_done_d;
    logic                          gr_prev_q, gr_prev_d;
    logic [DATA_WIDTH-1:0]         m_data_q, m_data_d;

    logic [IDX_W-1:0] cur_cnt;
    logic             in_ld, finish, beat, last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            fin_q     <= 1'b0;
            h_cnt_q   <= '0;
            ni_cnt_q  <= '0;
            w_cnt_q   <= '0;
            f_cnt_q   <= '0;
            h_done_q  <= 1'b0;
            ni_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            gr_prev_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            fin_q     <= fin_d;
            h_cnt_q   <= h_cnt_d;
            ni_cnt_q  <= ni_cnt_d;
            w_cnt_q   <= w_cnt_d;
            f_cnt_q   <= f_cnt_d;
            h_done_q  <= h_done_d;
            ni_done_q <= ni_done_d;
            w_done_q  <= w_done_d;
            gr_prev_q <= gr_prev_d;
            m_data_q  <= m_data_d;
        end
    end

    // Each load phase is cnt beat cycles plus one closing cycle (s_ready low) that advances.
    always_comb begin
        cur_cnt = '0;
        case (state_q)
            S_LD_H:  cur_cnt = IDX_W'(h_cnt_q);
            S_LD_NI: cur_cnt = IDX_W'(ni_cnt_q);
            S_LD_W:  cur_cnt = IDX_W'(w_cnt_q);
            default: cur_cnt = '0;
        endcase
        in_ld  = (state_q == S_LD_H) || (state_q == S_LD_NI) || (state_q == S_LD_W);
        finish = in_ld && (fin_q || (cur_cnt == '0));
        beat   = in_ld && !finish && s_valid;
        last   = beat && (idx_q == cur_cnt - IDX_W'(1));
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        fin_d     = fin_q;
        h_cnt_d   = h_cnt_q;
        ni_cnt_d  = ni_cnt_q;
        w_cnt_d   = w_cnt_q;
        f_cnt_d   = f_cnt_q;
        h_done_d  = h_done_q;
        ni_done_d = ni_done_q;
        w_done_d  = w_done_q;
        gr_prev_d = gr_prev_q;
        m_data_d  = m_data_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    h_cnt_d   = h_data_cnt;
                    ni_cnt_d  = node_info_cnt;
                    w_cnt_d   = wgt_cnt;
                    f_cnt_d   = feat_cnt;
                    h_done_d  = 1'b0;
                    ni_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    idx_d     = '0;
                    fin_d     = 1'b0;
                    state_d   = S_LD_H;
                end
            end
            S_LD_H, S_LD_NI, S_LD_W: begin
                if (beat) idx_d = idx_q + IDX_W'(1);
                if (last) fin_d = 1'b1;
                if (last || finish) begin
                    case (state_q)
                        S_LD_H:  h_done_d  = 1'b1;
                        S_LD_NI: ni_done_d = 1'b1;
                        default: w_done_d  = 1'b1;
                    endcase
                end
                if (finish) begin
                    fin_d = 1'b0;
                    idx_d = '0;
                    case (state_q)
                        S_LD_H:  state_d = S_LD_NI;
                        S_LD_NI: state_d = S_LD_W;
                        default: state_d = S_KICK;
                    endcase
                end
            end
            S_KICK: begin
                // Treat gat_ready as already high so a stale level cannot look like a rising edge.
                gr_prev_d = 1'b1;
                state_d   = S_RUN;
            end
            S_RUN: begin
                gr_prev_d = gat_ready;
                if (gat_ready && !gr_prev_q) begin
                    idx_d   = '0;
                    state_d = (f_cnt_q == '0) ? S_DONE : S_RD_ADDR;
                end
            end
            S_RD_ADDR: state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                m_data_d = feat_bram_dout;
                state_d  = S_RD_OUT;
            end
            S_RD_OUT: begin
                if (m_ready) begin
                    if (idx_q == IDX_W'(f_cnt_q) - IDX_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_RD_ADDR;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        s_ready   = in_ld && !finish;
        gat_layer = (state_q == S_KICK);
        m_valid   = (state_q == S_RD_OUT);
        m_data    = m_data_q;

        h_data_bram_ena      = beat && (state_q == S_LD_H);
        h_node_info_bram_ena = beat && (state_q == S_LD_NI);
        wgt_bram_ena         = beat && (state_q == S_LD_W);
        h_data_bram_wea      = h_data_bram_ena;
        h_node_info_bram_wea = h_node_info_bram_ena;
        wgt_bram_wea         = wgt_bram_ena;

        h_data_bram_din        = h_data_bram_ena ? s_data[H_DATA_WIDTH-1:0] : '0;
        h_node_info_bram_din   = h_node_info_bram_ena ? s_data[NODE_INFO_WIDTH-1:0] : '0;
        wgt_bram_din           = wgt_bram_ena ? s_data[DATA_WIDTH-1:0] : '0;
        h_data_bram_addra      = h_data_bram_ena ? {idx_q[H_DATA_ADDR_W-1:0], 2'b00} : '0;
        h_node_info_bram_addra = h_node_info_bram_ena ? {idx_q[NODE_INFO_ADDR_W-1:0], 2'b00} : '0;
        wgt_bram_addra         = wgt_bram_ena ? {idx_q[WEIGHT_ADDR_W-1:0], 2'b00} : '0;

        // Address held through the wait cycle so a registered-output BRAM sees it stable.
        feat_bram_addrb = ((state_q == S_RD_ADDR) || (state_q == S_RD_WAIT))
                        ? {idx_q[NEW_FEATURE_ADDR_W-1:0], 2'b00} : '0;

        h_data_bram_load_done      = h_done_q;
        h_node_info_bram_load_done = ni_done_q;
        wgt_bram_load_done         = w_done_q;
    end

endmodule

// File: tb/tb_gat_layer_scheduler.sv
// Scoreboard bench for gat_layer_scheduler: BRAM writes and feature stream checked against queues.
module tb_gat_layer_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [18:0] h_data_cnt = '0;
    logic [14:0] node_info_cnt = '0;
    logic [15:0] wgt_cnt = '0;
    logic [16:0] feat_cnt = '0;
    logic        busy, done;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [18:0] h_data_bram_din;
    logic        h_data_bram_ena, h_data_bram_wea;
    logic [19:0] h_data_bram_addra;
    logic [19:0] h_node_info_bram_din;
    logic        h_node_info_bram_ena, h_node_info_bram_wea;
    logic [15:0] h_node_info_bram_addra;
    logic [7:0]  wgt_bram_din;
    logic        wgt_bram_ena, wgt_bram_wea;
    logic [16:0] wgt_bram_addra;
    logic        h_data_bram_load_done, h_node_info_bram_load_done, wgt_bram_load_done;
    logic        gat_layer;
    logic        gat_ready = 1'b0;
    logic [17:0] feat_bram_addrb;
    logic [7:0]  feat_bram_dout = '0;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;

    gat_layer_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .h_data_cnt(h_data_cnt), .node_info_cnt(node_info_cnt), .wgt_cnt(wgt_cnt), .feat_cnt(feat_cnt),
        .busy(busy), .done(done), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .h_data_bram_din(h_data_bram_din), .h_data_bram_ena(h_data_bram_ena),
        .h_data_bram_wea(h_data_bram_wea), .h_data_bram_addra(h_data_bram_addra),
        .h_node_info_bram_din(h_node_info_bram_din), .h_node_info_bram_ena(h_node_info_bram_ena),
        .h_node_info_bram_wea(h_node_info_bram_wea), .h_node_info_bram_addra(h_node_info_bram_addra),
        .wgt_bram_din(wgt_bram_din), .wgt_bram_ena(wgt_bram_ena),
        .wgt_bram_wea(wgt_bram_wea), .wgt_bram_addra(wgt_bram_addra),
        .h_data_bram_load_done(h_data_bram_load_done),
        .h_node_info_bram_load_done(h_node_info_bram_load_done),
        .wgt_bram_load_done(wgt_bram_load_done),
        .gat_layer(gat_layer), .gat_ready(gat_ready),
        .feat_bram_addrb(feat_bram_addrb), .feat_bram_dout(feat_bram_dout),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;
    wr_t        hq[$], nq[$], wq[$];
    logic [7:0] mq[$];
    logic [31:0] words[64];
    logic [7:0]  fmem[16];

    int n_cmp = 0, n_err = 0;
    int cyc = 0, st_cyc = 0, gl_cyc = 0, ni_rise = 0, done_cnt = 0;
    bit sb_on = 1'b0, gl_seen = 1'b0, done_seen = 1'b0;
    bit src_en = 1'b0, src_tog = 1'b0, src_clr = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) feat_bram_dout <= fmem[feat_bram_addrb[5:2]];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Word source: advances only on a beat seen at the preceding negedge.
    initial begin
        int  wptr = 0;
        bit  hs;
        forever begin
            @(negedge clk);
            hs = s_valid && s_ready;
            @(posedge clk);
            #1;
            if (src_clr) wptr = 0;
            else if (hs) wptr++;
            s_valid = src_en && (src_tog ? !s_valid : 1'b1);
            s_data  = words[wptr % 64];
        end
    end

    // Write / stream / event monitor.
    initial begin
        wr_t        e;
        logic [7:0] em;
        logic       pmv = 1'b0, pmr = 1'b0, pni = 1'b0;
        logic [7:0] pmd = '0;
        forever begin
            @(negedge clk);
            if (gat_layer) begin gl_seen = 1'b1; gl_cyc = cyc; end
            if (done) begin done_seen = 1'b1; done_cnt++; end
            if (h_node_info_bram_load_done && !pni) ni_rise = cyc;
            pni = h_node_info_bram_load_done;
            if (sb_on) begin
                if (h_data_bram_ena) begin
                    if (hq.size() == 0) chk("h_extra_write", 1, 0);
                    else begin
                        e = hq.pop_front();
                        chk("h_addr", 64'(h_data_bram_addra), 64'(e.a));
                        chk("h_din", 64'(h_data_bram_din), 64'(e.d));
                        chk("h_wea", 64'(h_data_bram_wea), 1);
                    end
                end
                if (h_node_info_bram_ena) begin
                    if (nq.size() == 0) chk("ni_extra_write", 1, 0);
                    else begin
                        e = nq.pop_front();
                        chk("ni_addr", 64'(h_node_info_bram_addra), 64'(e.a));
                        chk("ni_din", 64'(h_node_info_bram_din), 64'(e.d));
                    end
                end
                if (wgt_bram_ena) begin
                    if (wq.size() == 0) chk("w_extra_write", 1, 0);
                    else begin
                        e = wq.pop_front();
                        chk("w_addr", 64'(wgt_bram_addra), 64'(e.a));
                        chk("w_din", 64'(wgt_bram_din), 64'(e.d));
                    end
                end
                if (m_valid && pmv && !pmr) chk("m_stable", 64'(m_data), 64'(pmd));
                if (m_valid && m_ready) begin
                    if (mq.size() == 0) chk("m_extra_word", 1, 0);
                    else begin
                        em = mq.pop_front();
                        chk("m_data", 64'(m_data), 64'(em));
                    end
                end
            end
            pmv = m_valid; pmr = m_ready; pmd = m_data;
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1; st_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_layer(input int h, input int ni, input int w, input int f,
                             input bit tog, input bit gpre, input int mdel);
        int k;
        sb_on = 1'b1; src_en = 1'b0; src_clr = 1'b1;
        @(posedge clk); #2;
        src_clr = 1'b0;
        for (int i = 0; i < 64; i++) words[i] = $urandom;
        for (int i = 0; i < 16; i++) fmem[i] = 8'($urandom);
        if (mdel > 0) begin fmem[0] = 8'h11; fmem[1] = 8'h22; end
        for (int i = 0; i < h; i++)  hq.push_back('{32'(i * 4), 32'(words[i][18:0])});
        for (int i = 0; i < ni; i++) nq.push_back('{32'(i * 4), 32'(words[h + i][19:0])});
        for (int i = 0; i < w; i++)  wq.push_back('{32'(i * 4), 32'(words[h + ni + i][7:0])});
        for (int i = 0; i < f; i++)  mq.push_back(fmem[i]);
        h_data_cnt = 19'(h); node_info_cnt = 15'(ni); wgt_cnt = 16'(w); feat_cnt = 17'(f);
        gat_ready = gpre; m_ready = (mdel == 0); src_tog = tog; src_en = 1'b1;
        gl_seen = 1'b0; done_seen = 1'b0; done_cnt = 0;
        pulse_start();
        @(negedge clk);
        chk("flags_cleared", {h_data_bram_load_done, h_node_info_bram_load_done, wgt_bram_load_done}, 0);
        chk("busy_on", 64'(busy), 1);
        for (k = 0; k < 500 && !gl_seen; k++) @(negedge clk);
        chk("gat_layer_seen", 64'(gl_seen), 1);
        if (!tog) chk("gat_layer_latency", 64'(gl_cyc - st_cyc), 64'(h + ni + w + 4));
        if (ni == 0) chk("ni_done_rise", 64'(ni_rise - st_cyc), 64'(h + 3));
        if (gpre) begin
            repeat (4) @(negedge clk);
            chk("run_waits_stale_ready", {busy, m_valid, m_data == m_data}, 3'b101);
            @(posedge clk); #1 gat_ready = 1'b0;
            repeat (2) @(posedge clk);
            #1 gat_ready = 1'b1;
        end else begin
            repeat (3) @(posedge clk);
            #1 gat_ready = 1'b1;
        end
        if (mdel > 0) begin
            for (k = 0; k < 100 && !m_valid; k++) @(negedge clk);
            chk("m_valid_seen", 64'(m_valid), 1);
            repeat (mdel) @(posedge clk);
            #1 m_ready = 1'b1;
        end
        for (k = 0; k < 500 && !done_seen; k++) @(negedge clk);
        chk("done_seen", 64'(done_seen), 1);
        @(negedge clk);
        chk("idle_after", {busy, done}, 0);
        chk("done_one_cycle", 64'(done_cnt), 1);
        chk("flags_set", {h_data_bram_load_done, h_node_info_bram_load_done, wgt_bram_load_done}, 3'b111);
        chk("sb_drained", 64'(hq.size() + nq.size() + wq.size() + mq.size()), 0);
        gat_ready = 1'b0; src_en = 1'b0;
    endtask

    initial begin
        int k;
        for (int i = 0; i < 64; i++) words[i] = '0;
        for (int i = 0; i < 16; i++) fmem[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", {busy, done, s_ready, gat_layer, m_valid, h_data_bram_ena,
                            h_node_info_bram_ena, wgt_bram_ena}, 0);
        chk("rst_flags", {h_data_bram_load_done, h_node_info_bram_load_done, wgt_bram_load_done}, 0);
        chk("rst_addr", {feat_bram_addrb, m_data}, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        run_layer(4, 3, 5, 2, 1'b0, 1'b0, 0);
        run_layer(6, 2, 3, 3, 1'b1, 1'b0, 0);
        run_layer(3, 0, 2, 1, 1'b0, 1'b0, 0);
        run_layer(2, 2, 2, 2, 1'b0, 1'b1, 0);
        run_layer(2, 1, 2, 2, 1'b0, 1'b0, 5);
        run_layer(1, 1, 1, 0, 1'b0, 1'b0, 0);

        // Abort in the weight phase, then a clean full layer.
        sb_on = 1'b0;
        h_data_cnt = 19'd4; node_info_cnt = 15'd3; wgt_cnt = 16'd5; feat_cnt = 17'd2;
        src_tog = 1'b0; src_en = 1'b1;
        pulse_start();
        for (k = 0; k < 100 && !wgt_bram_ena; k++) @(negedge clk);
        chk("abort_in_ld_w", 64'(wgt_bram_ena), 1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_outputs", {busy, s_ready, wgt_bram_ena, wgt_bram_wea, gat_layer, m_valid, done}, 0);
        chk("abort_flags", {h_data_bram_load_done, h_node_info_bram_load_done, wgt_bram_load_done}, 0);
        chk("abort_addr", 64'(wgt_bram_addra), 0);
        @(posedge clk); #1 rst_n = 1'b1; src_en = 1'b0;
        run_layer(4, 3, 5, 2, 1'b0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
